// File: rtl/temp_sensor_ctrl.sv
// temp_sensor_ctrl: drives an i2c_master through pointer-write + repeated-start
// two-byte read transactions and publishes the 16-bit raw sample.
// Optional feature macro: TSC_RETRY_EN (retry ack-error aborts, 3 attempts total).
module temp_sensor_ctrl #(
  parameter logic [6:0] SENSOR_ADDR    = 7'b1001011,
  parameter logic [7:0] PTR_REG        = 8'h00,
  parameter int         POLL_CYCLES    = 50_000_000,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        auto_en,
  output logic        i2c_ena,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_data_wr,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_data_rd,
  input  logic        i2c_ack_error,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        err,
  output logic        busy
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_B1, WAIT_B2, WAIT_B3, WAIT_END, DONE, ABORT
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q;
  logic [PW-1:0]   poll_q, poll_d;
  logic [TW-1:0]   to_q, to_d;
  logic            ena_q, ena_d, rw_q, rw_d;
  logic [7:0]      msb_q, msb_d, lsb_q, lsb_d;
  logic [15:0]     temp_q, temp_d;
  logic            valid_q, valid_d, err_q, err_d;
`ifdef TSC_RETRY_EN
  logic            ack_abort_q, ack_abort_d;
  logic [1:0]      retry_q, retry_d;
`endif

  logic rise, fall, poll_exp, to_hit, in_wait;

  // Next-state, counters and registered-output values
  always_comb begin
    rise     = i2c_busy & ~busy_q;
    fall     = ~i2c_busy & busy_q;
    poll_exp = auto_en && (poll_q == POLL_MAX);
    to_hit   = (to_q == TO_MAX);
    in_wait  = (state_q == WAIT_B1) || (state_q == WAIT_B2) ||
               (state_q == WAIT_B3) || (state_q == WAIT_END);

    state_d = state_q;
    ena_d   = ena_q;
    rw_d    = rw_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef TSC_RETRY_EN
    ack_abort_d = ack_abort_q;
    retry_d     = retry_q;
`endif

    // Poll timer free-runs while enabled so automatic starts stay evenly spaced
    poll_d = (!auto_en || poll_exp) ? '0 : poll_q + 1'b1;

    case (state_q)
      IDLE: begin
`ifdef TSC_RETRY_EN
        retry_d = '0;
`endif
        if (start || poll_exp) state_d = START;
      end
      START: begin
        ena_d   = 1'b1;
        rw_d    = 1'b0;
        state_d = WAIT_B1;
      end
      WAIT_B1: if (rise) begin
        rw_d    = 1'b1;          // pointer byte latched: next command is a read
        state_d = WAIT_B2;
      end
      WAIT_B2: if (rise) state_d = WAIT_B3;
      WAIT_B3: if (rise) begin
        msb_d   = i2c_data_rd;
        ena_d   = 1'b0;          // master NACKs the LSB and issues stop
        state_d = WAIT_END;
      end
      WAIT_END: if (fall) begin
        lsb_d   = i2c_data_rd;
        state_d = DONE;
      end
      DONE: begin
        temp_d  = {msb_q, lsb_q};
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ABORT: if (!i2c_busy || to_hit) begin
`ifdef TSC_RETRY_EN
        if (ack_abort_q && (retry_q < 2'd2)) begin
          retry_d = retry_q + 2'd1;
          state_d = START;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`else
        err_d   = 1'b1;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Ack error or a stalled wait overrides normal progress
    if (in_wait && (i2c_ack_error || to_hit)) begin
      ena_d   = 1'b0;
      state_d = ABORT;
`ifdef TSC_RETRY_EN
      ack_abort_d = i2c_ack_error;
`endif
    end

    // Timeout counter restarts on every state change and sleeps in IDLE
    to_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : to_q + 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      poll_q  <= '0;
      to_q    <= '0;
      ena_q   <= 1'b0;
      rw_q    <= 1'b0;
      msb_q   <= '0;
      lsb_q   <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef TSC_RETRY_EN
      ack_abort_q <= 1'b0;
      retry_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= i2c_busy;
      poll_q  <= poll_d;
      to_q    <= to_d;
      ena_q   <= ena_d;
      rw_q    <= rw_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef TSC_RETRY_EN
      ack_abort_q <= ack_abort_d;
      retry_q     <= retry_d;
`endif
    end
  end

  assign i2c_ena     = ena_q;
  assign i2c_addr    = SENSOR_ADDR;
  assign i2c_rw      = rw_q;
  assign i2c_data_wr = PTR_REG;
  assign temp_data   = temp_q;
  assign temp_valid  = valid_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_temp_sensor_ctrl.sv
// Bench for temp_sensor_ctrl: behavioural i2c_master model plus a scoreboard of
// expected temp_valid / err events.
module tb_temp_sensor_ctrl;
  localparam int BT = 20;     // cycles busy is held per master command

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic        i2c_ena, i2c_rw, i2c_busy, i2c_ack_error;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_data_wr, i2c_data_rd;
  logic [15:0] temp_data;
  logic        temp_valid, err, busy;

  temp_sensor_ctrl #(.POLL_CYCLES(1000), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .auto_en(auto_en),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_wr(i2c_data_wr), .i2c_busy(i2c_busy), .i2c_data_rd(i2c_data_rd),
    .i2c_ack_error(i2c_ack_error), .temp_data(temp_data),
    .temp_valid(temp_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic is_err; logic [15:0] data; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  logic       rw_log[$];

  // ---------------- i2c_master model ----------------
  logic m_busy = 1'b0, m_ack = 1'b0, stuck = 1'b0, nack_mode = 1'b0, rw_cur = 1'b0;
  logic [7:0] m_rd = 8'h00;
  int m_st = 0, m_cnt = 0, m_nseg = 0, last_nseg = 0;
  assign i2c_busy      = m_busy | stuck;
  assign i2c_ack_error = m_ack;
  assign i2c_data_rd   = m_rd;

  task automatic seg_start();
    m_busy = 1'b1; m_cnt = 0; m_nseg++; rw_cur = i2c_rw;
    rw_log.push_back(i2c_rw); m_st = 1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      m_st = 0; m_busy = 1'b0; m_ack = 1'b0; m_cnt = 0;
    end else begin
      case (m_st)
        0: if (i2c_ena && !stuck) begin m_nseg = 0; seg_start(); end
        1: begin
          m_cnt++;
          if (m_cnt == BT) begin
            m_busy = 1'b0;
            if (nack_mode && m_nseg == 1) m_ack = 1'b1;
            else if (rw_cur && rd_q.size() > 0) m_rd = rd_q.pop_front();
            m_st = 2;
          end
        end
        default: if (!i2c_ena) begin
          m_ack = 1'b0; last_nseg = m_nseg; m_st = 0;
        end else if (!m_ack) seg_start();
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0, ena_rises = 0;
  int rise_cyc[$];
  logic prev_ena = 1'b0, prev_busy = 1'b0;
  always @(posedge clk) cyc++;

  task automatic sb_pop(input logic is_err);
    exp_t e;
    if (exp_q.size() == 0) chk(is_err ? "unexpected_err" : "unexpected_valid", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("sb_kind", is_err, e.is_err);
      if (!is_err) chk("sb_data", temp_data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (i2c_ena && !prev_ena) ena_rises++;
      if (busy && !prev_busy) rise_cyc.push_back(cyc);
      if (temp_valid && err) chk("valid_err_same_cycle", 1, 0);
      if (temp_valid) sb_pop(1'b0);
      if (err) sb_pop(1'b1);
    end
    prev_ena  = i2c_ena;
    prev_busy = busy;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((busy || m_st != 0) && n < max) begin @(negedge clk); n++; end
    chk({tag, "_idle_timeout"}, (n >= max), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_txn(input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    rd_q.push_back(b1); rd_q.push_back(b2);
    e.is_err = 1'b0; e.data = {b1, b2};
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.data = 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] b1, input logic [7:0] b2);
    rw_log.delete();
    push_txn(b1, b2);
    pulse_start();
    wait_idle(tag, 400);
    chk({tag, "_temp"}, temp_data, {b1, b2});
    chk({tag, "_nseg"}, last_nseg, 3);
    chk({tag, "_rwcnt"}, rw_log.size(), 3);
    if (rw_log.size() == 3) chk({tag, "_rwseq"}, {rw_log[0], rw_log[1], rw_log[2]}, 3'b011);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic ena_mid;
    // Reset held with start asserted
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("rst_ena", i2c_ena, 0); end
    chk("rst_rw", i2c_rw, 0);
    chk("rst_data_wr", i2c_data_wr, 8'h00);
    chk("rst_addr", i2c_addr, 7'h4B);
    chk("rst_temp", temp_data, 0);
    chk("rst_valid", temp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 start = 1'b0; reset_n = 1'b1;

    // First read: check start-to-ena latency
    rw_log.delete();
    push_txn(8'h19, 8'h80);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_ena_early", i2c_ena, 0);
    @(posedge clk); #1;
    chk("lat_ena", i2c_ena, 1);
    chk("lat_rw", i2c_rw, 0);
    wait_idle("t1", 400);
    chk("t1_temp", temp_data, 16'h1980);
    chk("t1_nseg", last_nseg, 3);
    chk("t1_rwcnt", rw_log.size(), 3);
    if (rw_log.size() == 3) chk("t1_rwseq", {rw_log[0], rw_log[1], rw_log[2]}, 3'b011);

    read_txn("t2", 8'hA5, 8'h3C);

    // Address NACK
    nack_mode = 1'b1; ena_rises = 0;
    push_err();
    pulse_start();
    wait_idle("nack", 600);
`ifdef TSC_RETRY_EN
    chk("nack_attempts", ena_rises, 3);
`else
    chk("nack_attempts", ena_rises, 1);
`endif
    chk("nack_temp_hold", temp_data, 16'hA53C);
    nack_mode = 1'b0;

    // Busy stuck high: timeout in wait state, then timeout in ABORT
    stuck = 1'b1;
    push_err();
    pulse_start();
    n = 0; ena_mid = 1'b1;
    while (!err && n < 300) begin
      @(negedge clk); n++;
      if (n == 150) ena_mid = i2c_ena;
    end
    chk("stuck_err_seen", err, 1);
    chk("stuck_err_latency_ok", (n <= 202), 1);
    chk("stuck_ena_in_abort", ena_mid, 0);
    chk("stuck_ena", i2c_ena, 0);
    stuck = 1'b0;
    wait_idle("stuck", 50);
    chk("stuck_busy", busy, 0);

    // Automatic polling, with an ignored start mid-transaction
    push_txn(8'h12, 8'h34); push_txn(8'h56, 8'h78); push_txn(8'h9A, 8'hBC);
    rise_cyc.delete();
    @(posedge clk); #1 auto_en = 1'b1;
    n = 0;
    while (rise_cyc.size() < 1 && n < 1200) begin @(negedge clk); n++; end
    chk("auto_first_timeout", (n >= 1200), 0);
    repeat (30) @(negedge clk);
    chk("auto_busy_mid", busy, 1);
    pulse_start();
    n = 0;
    while (rise_cyc.size() < 3 && n < 2500) begin @(negedge clk); n++; end
    chk("auto_third_timeout", (n >= 2500), 0);
    auto_en = 1'b0;
    wait_idle("auto", 400);
    repeat (100) @(negedge clk);
    chk("auto_count", rise_cyc.size(), 3);
    if (rise_cyc.size() >= 3) begin
      chk("auto_gap1", rise_cyc[1] - rise_cyc[0], 1000);
      chk("auto_gap2", rise_cyc[2] - rise_cyc[1], 1000);
    end
    chk("auto_temp", temp_data, 16'h9ABC);

    // Reset during WAIT_B2
    rd_q.push_back(8'hEE); rd_q.push_back(8'hEE);
    pulse_start();
    n = 0;
    while (!(m_st == 1 && m_nseg == 1 && m_cnt == 5) && n < 200) begin @(negedge clk); n++; end
    chk("mid_reach_timeout", (n >= 200), 0);
    #2 reset_n = 1'b0;
    #1 chk("mid_ena_async", i2c_ena, 0);
    rd_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_temp_reset", temp_data, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 0);
    read_txn("post", 8'hDE, 8'hAD);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
